serial_descrambler_rx: RTL
==========================

# serial_descrambler_rx

Serial receive front-end for the far end of the scrambled serial link. Takes the one-bit line stream (start bit, scrambled data, optional parity), descrambles it with the link's additive LFSR, and delivers each recovered word on a two-phase (toggle) req/ack port. Sits between the line input and any consumer on the packet bus. Inverts the scrambler + serializer path.

## Interface
- DATA_W, 8, payload bits per frame (2..32)
- SEED, 7'h7F, LFSR seed loaded at every start bit (must be non-zero)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- din  input  1  serial line, one bit per clk, idle level 0
- data_o  output  DATA_W  last delivered descrambled word
- req_o  output  1  two-phase request, toggles once per delivered word
- ack_i  input  1  two-phase acknowledge, consumer sets ack_i = req_o to accept (synchronous to clk)
- par_err_o  output  1  one-cycle pulse, frame dropped for parity error
- ovr_o  output  1  one-cycle pulse, frame dropped because previous word not yet acknowledged

## Operation
- Frame on din: start bit 1, then DATA_W scrambled bits LSB first, then 1 even-parity bit (with DESCRAMBLER_PARITY_EN). Line idles at 0.
- FSM states: IDLE, SHIFT, PAR, DONE.
- IDLE: din = 1 -> load LFSR with SEED, clear bit counter, go SHIFT. din = 0 -> stay.
- SHIFT: per cycle, k = s[6] ^ s[5]; store din ^ k into shift register at position = counter; s <= {s[5:0], k}. Running parity ^= din (scrambled bit). After bit DATA_W-1 -> PAR (parity enabled) or DONE (disabled).
- PAR: sample din; total ones over scrambled bits + parity bit must be even. Go DONE.
- DONE (one cycle, no din sampling): if parity bad -> pulse par_err_o, no delivery. Otherwise, if req_o == ack_i (port free) -> data_o <= word, req_o <= ~req_o. Otherwise -> pulse ovr_o, data_o and req_o unchanged. Return to IDLE.
- Port busy = req_o != ack_i. data_o stable for the whole time the port is busy.
- Parity error takes precedence over overrun; both never pulse in the same cycle.
- Bit counter width clog2(DATA_W); no wrap beyond DATA_W-1.

## Timing
- Reset (rst = 0, async): state IDLE, data_o = 0, req_o = 0, par_err_o = 0, ovr_o = 0, LFSR = SEED, counter = 0.
- Reset mid-frame: partial frame discarded; after release, the next 1 seen in IDLE is treated as a start bit (caller keeps line at 0 until the link is aligned).
- Latency: req_o toggles / data_o updates on the edge after DONE, i.e. 2 cycles after the last frame bit is sampled.
- Frame length 1 + DATA_W + 1 cycles, plus 1 DONE cycle; next start bit accepted at earliest 1 cycle after DONE (back-to-back frames need 1 idle bit).
- ack_i toggling in the DONE cycle counts: the comparison uses the current ack_i, so the new word is accepted, not an overrun.
- ack_i toggling while port free (ack_i != req_o after it matched) is a protocol violation; behaviour undefined, no checking.
- par_err_o, ovr_o: high exactly one cycle, registered.

## Configuration
- DESCRAMBLER_PARITY_EN defined: frame carries a parity bit, PAR state present, par_err_o driven as above.
- Not defined: no parity bit, SHIFT goes directly to DONE, frame is 1 + DATA_W bits, par_err_o tied to 0.

## Test plan
- Reset: hold rst = 0 with din toggling -> all outputs 0, no req_o toggle; release, din = 0 for 20 cycles -> no activity.
- Basic (DATA_W = 8, SEED = 7'h7F, parity on): din = 1, then bits of 8'h40 LSB first, parity 1 -> data_o = 8'h00, req_o 0->1 two cycles after the parity bit.
- Inverse: start, bits of 8'h00, parity 0 -> data_o = 8'h40; ack_i set to req_o; repeat with same frame -> identical data_o (LFSR reseeds per frame).
- Parity error: scrambled 8'h40 with parity 0 -> par_err_o one-cycle pulse, req_o and data_o unchanged.
- Overrun: deliver one word, hold ack_i; send second frame -> ovr_o pulse, data_o keeps first word; then toggle ack_i in the DONE cycle of a third frame -> third word delivered, no ovr_o.
- Reset mid-frame: assert rst after 4 data bits -> outputs cleared, next full frame decodes correctly.

Source files
------------

// File: rtl/serial_descrambler_rx_if.sv
// Delivery port of serial_descrambler_rx: descrambled word on a two-phase req/ack
// handshake plus the one-cycle drop pulses.
interface serial_descrambler_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_o;
    logic              req_o;
    logic              ack_i;
    logic              par_err_o;
    logic              ovr_o;

    modport master (
        output data_o, req_o, par_err_o, ovr_o,
        input  ack_i
    );

    modport slave (
        input  data_o, req_o, par_err_o, ovr_o,
        output ack_i
    );
endinterface

// File: rtl/serial_descrambler_rx.sv
// Serial receiver: start bit, DATA_W scrambled bits LSB first, optional even parity
// (enabled by macro DESCRAMBLER_PARITY_EN); additive LFSR descramble, toggle req/ack out.
module serial_descrambler_rx #(
    parameter int         DATA_W = 8,
    parameter logic [6:0] SEED   = 7'h7F
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din,
    serial_descrambler_rx_if.master bus
);
`ifdef DESCRAMBLER_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam int               CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;

    state_t            state_q;
    logic [6:0]        lfsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] data_q;
    logic              par_q;
    logic              par_bad_q;
    logic              req_q;
    logic              perr_q;
    logic              ovr_q;
    logic              k;

    assign k = lfsr_q[6] ^ lfsr_q[5];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            cnt_q     <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            par_bad_q <= 1'b0;
            req_q     <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            ovr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (din) begin
                        lfsr_q    <= SEED;
                        cnt_q     <= '0;
                        par_q     <= 1'b0;
                        par_bad_q <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Parity covers the line (scrambled) bits, not the recovered ones.
                    sh_q[cnt_q] <= din ^ k;
                    lfsr_q      <= {lfsr_q[5:0], k};
                    par_q       <= par_q ^ din;
                    if (cnt_q == LAST) begin
                        if (PAR_EN) state_q <= PAR;
                        else        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PAR: begin
                    par_bad_q <= par_q ^ din;
                    state_q   <= DONE;
                end
                DONE: begin
                    // Live ack_i is used so an ack landing in this cycle frees the port.
                    if (par_bad_q) begin
                        perr_q <= 1'b1;
                    end else if (req_q == bus.ack_i) begin
                        data_q <= sh_q;
                        req_q  <= ~req_q;
                    end else begin
                        ovr_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_o    = data_q;
    assign bus.req_o     = req_q;
    assign bus.par_err_o = perr_q & PAR_EN;
    assign bus.ovr_o     = ovr_q;
endmodule
